cordic_entry_ctrl: RTL and testbench

//   Operand-entry responder inside Top: decodes the st/sw_in stepping protocol
//   (function code, op1, op2, go, result-ack) into a registered CORDIC request.

---
 rtl/cordic_entry_ctrl_pkg.sv | 37 +++
 rtl/cordic_entry_ctrl_st_edge.sv | 40 ++++
 rtl/cordic_entry_ctrl.sv | 118 +++++++++++
 tb/tb_cordic_entry_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_entry_ctrl_pkg.sv
// Shared definitions for the CORDIC operand-entry controller: widths, state
// encoding, function-code table and small code-classification helpers.
package cordic_entry_ctrl_pkg;

  localparam int W         = 16;
  localparam int FUNC_W    = 4;
  localparam int NUM_FUNCS = 9;

  // Bit k set: function k takes both op1 and op2 (codes 0, 1, 7).
  localparam logic [NUM_FUNCS-1:0] TWO_OP_MASK = 9'b010000011;

  // Q2.14 unity.
  localparam logic [W-1:0] Q_ONE = 16'h4000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FUNC = 3'd1,
    S_OP1  = 3'd2,
    S_OP2  = 3'd3,
    S_GO   = 3'd4,
    S_RUN  = 3'd5,
    S_SHOW = 3'd6
  } state_e;

  function automatic logic code_valid(input logic [FUNC_W-1:0] code);
    return (int'(code) < NUM_FUNCS);
  endfunction

  // Only meaningful for valid codes; invalid codes report single-operand.
  function automatic logic code_two_op(input logic [FUNC_W-1:0] code);
    logic r;
    r = 1'b0;
    if (code_valid(code)) r = TWO_OP_MASK[code];
    return r;
  endfunction

endpackage

// File: rtl/cordic_entry_ctrl_st_edge.sv
// Step-strobe conditioning: optional 2-flop synchronizer (macro ST_SYNC_EN)
// followed by a rising-edge detector producing a one-cycle stp pulse.
module cordic_entry_ctrl_st_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic st,
  output logic stp
);

`ifdef ST_SYNC_EN
  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= st;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign stp = r_sync2 & ~r_prev;
`else
  logic r_st_q;

  // st is assumed synchronous to clk here, so the edge can be taken directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_st_q <= 1'b0;
    else        r_st_q <= st;
  end

  assign stp = st & ~r_st_q;
`endif

endmodule

// File: rtl/cordic_entry_ctrl.sv
// Operand-entry FSM for the CORDIC core: steps through function code, op1,
// op2 and go on each st edge, launches the core and shows its result.
// Build option: ST_SYNC_EN adds a 2-flop synchronizer on st.
module cordic_entry_ctrl
  import cordic_entry_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st,
  input  logic [W-1:0]      sw_in,
  output logic              core_start,
  output logic [FUNC_W-1:0] core_func,
  output logic [W-1:0]      core_op1,
  output logic [W-1:0]      core_op2,
  input  logic              core_done,
  input  logic [W-1:0]      core_result,
  output logic [W-1:0]      disp_value,
  output logic [2:0]        state_o,
  output logic              err_o
);

  // Handshake: the core samples func/op1/op2 on the cycle core_start is high;
  // these stay stable until the next entry sequence overwrites them. The core
  // answers with a single-cycle core_done carrying core_result, which is only
  // honoured while the FSM is in S_RUN.

  logic              w_stp;
  logic [FUNC_W-1:0] w_code;

  state_e            r_state;
  logic [FUNC_W-1:0] r_func;
  logic [W-1:0]      r_op1;
  logic [W-1:0]      r_op2;
  logic [W-1:0]      r_result;
  logic              r_start;
  logic              r_err;

  cordic_entry_ctrl_st_edge u_st_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .st    (st),
    .stp   (w_stp)
  );

  assign w_code = sw_in[FUNC_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_func   <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_result <= '0;
      r_start  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_stp) r_state <= S_FUNC;
        end
        S_FUNC: begin
          if (w_stp) begin
            r_func <= w_code;
            if (!code_valid(w_code)) begin
              r_err <= 1'b1;
            end else if (code_two_op(w_code)) begin
              r_state <= S_OP1;
            end else begin
              r_op1   <= '0;
              r_state <= S_OP2;
            end
          end
        end
        S_OP1: begin
          if (w_stp) begin
            r_op1   <= sw_in;
            r_state <= S_OP2;
          end
        end
        S_OP2: begin
          if (w_stp) begin
            r_op2   <= sw_in;
            r_state <= S_GO;
          end
        end
        S_GO: begin
          if (w_stp) begin
            r_start <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          // A completion in the same cycle as a step wins; the step is dropped.
          if (core_done) begin
            r_result <= core_result;
            r_state  <= S_SHOW;
          end else if (w_stp) begin
            r_err <= 1'b1;
          end
        end
        S_SHOW: begin
          if (w_stp) r_state <= S_FUNC;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign core_start = r_start;
  assign core_func  = r_func;
  assign core_op1   = r_op1;
  assign core_op2   = r_op2;
  assign err_o      = r_err;
  assign state_o    = r_state;
  assign disp_value = (r_state == S_SHOW) ? r_result : sw_in;

endmodule

// File: tb/tb_cordic_entry_ctrl.sv
// Directed testbench for cordic_entry_ctrl; follows the ST_SYNC_EN build
// option for the expected st-to-advance latency.
module tb_cordic_entry_ctrl;
  import cordic_entry_ctrl_pkg::*;

`ifdef ST_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic              clk;
  logic              rst_n;
  logic              st;
  logic [W-1:0]      sw_in;
  logic              core_start;
  logic [FUNC_W-1:0] core_func;
  logic [W-1:0]      core_op1;
  logic [W-1:0]      core_op2;
  logic              core_done;
  logic [W-1:0]      core_result;
  logic [W-1:0]      disp_value;
  logic [2:0]        state_o;
  logic              err_o;

  int total;
  int bad;
  int start_hi;

  cordic_entry_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .st          (st),
    .sw_in       (sw_in),
    .core_start  (core_start),
    .core_func   (core_func),
    .core_op1    (core_op1),
    .core_op2    (core_op2),
    .core_done   (core_done),
    .core_result (core_result),
    .disp_value  (disp_value),
    .state_o     (state_o),
    .err_o       (err_o)
  );

  // Clock and reset-time defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts cycles in which core_start is high.
  always @(negedge clk) begin
    if (core_start === 1'b1) start_hi++;
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic [W-1:0] v);
    @(negedge clk);
    sw_in = v;
    st    = 1'b1;
    repeat (LAT) @(posedge clk);
    @(negedge clk);
    st = 1'b0;
    repeat (LAT + 1) @(negedge clk);
  endtask

  task automatic pulse_done(input logic [W-1:0] r);
    @(negedge clk);
    core_done   = 1'b1;
    core_result = r;
    @(negedge clk);
    core_done   = 1'b0;
    core_result = '0;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    st = 1'b0;
    sw_in = 16'hABCD;
    core_done = 1'b0;
    core_result = '0;
    repeat (3) @(negedge clk);
    total++; if (state_o !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_o); end
    total++; if (core_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", core_start); end
    total++; if ({core_func, core_op1, core_op2} !== '0) begin bad++; $display("FAIL reset_regs got=%h/%h/%h exp=0", core_func, core_op1, core_op2); end
    total++; if (disp_value !== 16'hABCD) begin bad++; $display("FAIL reset_disp got=%h exp=abcd", disp_value); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_func0();
    int n0;
    step(16'h0000);
    total++; if (state_o !== 3'd1) begin bad++; $display("FAIL f0_idle_to_func got=%0d exp=1", state_o); end
    step(16'h0000);
    total++; if (state_o !== 3'd2) begin bad++; $display("FAIL f0_to_op1 got=%0d exp=2", state_o); end
    step(Q_ONE);
    total++; if (state_o !== 3'd3) begin bad++; $display("FAIL f0_to_op2 got=%0d exp=3", state_o); end
    step(16'h0000);
    total++; if (state_o !== 3'd4) begin bad++; $display("FAIL f0_to_go got=%0d exp=4", state_o); end
    total++; if (core_func !== 4'd0 || core_op1 !== 16'h4000 || core_op2 !== 16'h0000) begin
      bad++; $display("FAIL f0_operands got=%h/%h/%h exp=0/4000/0000", core_func, core_op1, core_op2);
    end
    n0 = start_hi;
    step(16'h0000);
    total++; if (state_o !== 3'd5) begin bad++; $display("FAIL f0_to_run got=%0d exp=5", state_o); end
    total++; if (start_hi - n0 !== 1) begin bad++; $display("FAIL f0_start_cycles got=%0d exp=1", start_hi - n0); end
    sw_in = 16'hBEEF;
    pulse_done(16'h5555);
    total++; if (state_o !== 3'd6) begin bad++; $display("FAIL f0_to_show got=%0d exp=6", state_o); end
    total++; if (disp_value !== 16'h5555) begin bad++; $display("FAIL f0_disp got=%h exp=5555", disp_value); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL f0_err got=%b exp=0", err_o); end
  endtask

  task automatic test_func3();
    int n0;
    step(16'h0000);
    total++; if (state_o !== 3'd1) begin bad++; $display("FAIL f3_show_to_func got=%0d exp=1", state_o); end
    total++; if (disp_value !== 16'h0000) begin bad++; $display("FAIL f3_disp_passthru got=%h exp=0000", disp_value); end
    step(16'h0003);
    total++; if (state_o !== 3'd3) begin bad++; $display("FAIL f3_skip_op1 got=%0d exp=3", state_o); end
    total++; if (core_op1 !== 16'h0000 || core_func !== 4'd3) begin bad++; $display("FAIL f3_func_op1 got=%h/%h exp=3/0000", core_func, core_op1); end
    step(16'h6488);
    total++; if (state_o !== 3'd4 || core_op2 !== 16'h6488) begin bad++; $display("FAIL f3_op2 got=%0d/%h exp=4/6488", state_o, core_op2); end
    n0 = start_hi;
    step(16'h7777);
    total++; if (start_hi - n0 !== 1) begin bad++; $display("FAIL f3_start_cycles got=%0d exp=1", start_hi - n0); end
    repeat (4) @(negedge clk);
    total++; if (core_func !== 4'd3 || core_op1 !== 16'h0000 || core_op2 !== 16'h6488) begin
      bad++; $display("FAIL f3_hold_in_run got=%h/%h/%h exp=3/0000/6488", core_func, core_op1, core_op2);
    end
    sw_in = 16'h9999;
    pulse_done(16'h1234);
    total++; if (state_o !== 3'd6 || disp_value !== 16'h1234) begin bad++; $display("FAIL f3_show got=%0d/%h exp=6/1234", state_o, disp_value); end
    // core_done outside S_RUN must leave the shown result alone.
    pulse_done(16'hEEEE);
    total++; if (state_o !== 3'd6 || disp_value !== 16'h1234) begin bad++; $display("FAIL f3_stray_done got=%0d/%h exp=6/1234", state_o, disp_value); end
  endtask

  task automatic test_bad_code();
    step(16'h0000);
    step(16'h0009);
    total++; if (state_o !== 3'd1) begin bad++; $display("FAIL bad_code_state got=%0d exp=1", state_o); end
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL bad_code_err got=%b exp=1", err_o); end
    step(16'h0007);
    total++; if (state_o !== 3'd2 || core_func !== 4'd7) begin bad++; $display("FAIL code7 got=%0d/%h exp=2/7", state_o, core_func); end
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err_o); end
  endtask

  task automatic test_run_stp();
    step(16'h1111);
    step(16'h2222);
    total++; if (core_op1 !== 16'h1111 || core_op2 !== 16'h2222) begin bad++; $display("FAIL f7_ops got=%h/%h exp=1111/2222", core_op1, core_op2); end
    step(16'h0000);
    total++; if (state_o !== 3'd5) begin bad++; $display("FAIL run_enter got=%0d exp=5", state_o); end
    step(16'h0000);
    total++; if (state_o !== 3'd5) begin bad++; $display("FAIL run_stp_ignored got=%0d exp=5", state_o); end
    // Line up core_done with the cycle in which stp is active.
    @(negedge clk);
    st = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    core_done = 1'b1;
    core_result = 16'h0F0F;
    @(negedge clk);
    core_done = 1'b0;
    core_result = '0;
    st = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    total++; if (state_o !== 3'd6) begin bad++; $display("FAIL done_wins got=%0d exp=6", state_o); end
    total++; if (disp_value !== 16'h0F0F) begin bad++; $display("FAIL done_wins_disp got=%h exp=0f0f", disp_value); end
  endtask

  task automatic test_hold();
    int lat;
    lat = 0;
    @(negedge clk);
    st = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (lat == 0 && state_o !== 3'd6) lat = i;
    end
    total++; if (lat !== LAT) begin bad++; $display("FAIL st_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (state_o !== 3'd1) begin bad++; $display("FAIL hold_one_advance got=%0d exp=1", state_o); end
    st = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    total++; if (state_o !== 3'd1) begin bad++; $display("FAIL hold_release got=%0d exp=1", state_o); end
  endtask

  task automatic test_reset_mid_run();
    step(16'h0001);
    step(16'h0100);
    step(16'h0200);
    @(negedge clk);
    sw_in = 16'h0000;
    st = 1'b1;
    repeat (LAT) @(posedge clk);
    #2;
    total++; if (core_start !== 1'b1 || state_o !== 3'd5) begin bad++; $display("FAIL pre_reset_run got=%b/%0d exp=1/5", core_start, state_o); end
    rst_n = 1'b0;
    st = 1'b0;
    #1;
    total++; if (core_start !== 1'b0 || state_o !== 3'd0) begin bad++; $display("FAIL async_reset got=%b/%0d exp=0/0", core_start, state_o); end
    total++; if ({core_func, core_op1, core_op2, disp_value, err_o} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h/%h/%h/%h/%b exp=0", core_func, core_op1, core_op2, disp_value, err_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_done(16'hDEAD);
    repeat (2) @(negedge clk);
    total++; if (state_o !== 3'd0 || disp_value !== 16'h0000) begin bad++; $display("FAIL late_done got=%0d/%h exp=0/0000", state_o, disp_value); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    start_hi = 0;
    test_reset();
    test_func0();
    test_func3();
    test_bad_code();
    test_run_stp();
    test_hold();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
